reaction_ctrl: RTL and testbench



---
 rtl/reaction_ctrl.sv | 161 ++++++++++++++++
 tb/tb_reaction_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_ctrl.sv
// Reaction-timer controller: random stimulus delay, then a BCD
// millisecond count until the player stops, is early or times out.
module reaction_ctrl #(
    parameter int MS_DIV       = 100_000,
    parameter int DELAY_MIN_MS = 2000,
    parameter int TIMEOUT_MS   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_tick,
    input  logic       stop_tick,
    input  logic       clear_tick,
    output logic       stim_led,
    output logic [3:0] bcd3,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       busy,
    output logic       early,
    output logic       timeout
);

    localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int DW = $clog2(DELAY_MIN_MS + 2048);

    localparam logic [PW-1:0] PRE_LAST = PW'(MS_DIV - 1);
    localparam logic [DW-1:0] DLY_MIN  = DW'(DELAY_MIN_MS);
    localparam logic [15:0]   TO_BCD   = {
        4'(TIMEOUT_MS / 1000 % 10),
        4'(TIMEOUT_MS / 100 % 10),
        4'(TIMEOUT_MS / 10 % 10),
        4'(TIMEOUT_MS % 10)
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_TIME,
        S_DONE,
        S_EARLY
    } state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [15:0]   bcd;
    logic [15:0]   bcd_nxt;
    logic [PW-1:0] presc;
    logic [DW-1:0] delay;
    logic          ms_tick;
    logic          fb;

    // Four-digit decimal increment, carrying through nines.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign ms_tick = (presc == PRE_LAST);
    assign bcd_nxt = bcd_inc(bcd);

    assign {bcd3, bcd2, bcd1, bcd0} = bcd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            lfsr     <= 16'hACE1;
            presc    <= '0;
            delay    <= '0;
            bcd      <= '0;
            stim_led <= 1'b0;
            busy     <= 1'b0;
            early    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            lfsr  <= {lfsr[14:0], fb};
            presc <= ms_tick ? '0 : presc + PW'(1);
            if (clear_tick) begin
                state    <= S_IDLE;
                presc    <= '0;
                delay    <= '0;
                bcd      <= '0;
                stim_led <= 1'b0;
                busy     <= 1'b0;
                early    <= 1'b0;
                timeout  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE, S_DONE, S_EARLY: begin
                        if (start_tick) begin
                            state    <= S_WAIT;
                            presc    <= '0;
                            delay    <= DLY_MIN + DW'(lfsr[10:0]);
                            bcd      <= '0;
                            stim_led <= 1'b0;
                            busy     <= 1'b1;
                            early    <= 1'b0;
                            timeout  <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (stop_tick) begin
                            state <= S_EARLY;
                            presc <= '0;
                            delay <= '0;
                            bcd   <= 16'h9999;
                            busy  <= 1'b0;
                            early <= 1'b1;
                        end else if (ms_tick) begin
                            if (delay < DW'(2)) begin
                                state    <= S_TIME;
                                presc    <= '0;
                                delay    <= '0;
                                bcd      <= '0;
                                stim_led <= 1'b1;
                            end else begin
                                delay <= delay - DW'(1);
                            end
                        end
                    end
                    S_TIME: begin
                        // A stop on a tick edge freezes the pre-edge count.
                        if (stop_tick) begin
                            state    <= S_DONE;
                            presc    <= '0;
                            stim_led <= 1'b0;
                            busy     <= 1'b0;
                        end else if (ms_tick) begin
                            bcd <= bcd_nxt;
                            if (bcd_nxt == TO_BCD) begin
                                state    <= S_DONE;
                                presc    <= '0;
                                stim_led <= 1'b0;
                                busy     <= 1'b0;
                                timeout  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        presc <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboard bench for reaction_ctrl: expected output changes are
// queued with their edge number and popped by an independent monitor.
module tb_reaction_ctrl;

    localparam int MSDIV = 10;
    localparam int DMIN  = 5;
    localparam int TMO   = 1000;

    localparam int P_START = 0;
    localparam int P_STOP  = 1;
    localparam int P_CLEAR = 2;
    localparam int P_SC    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_tick;
    logic       stop_tick;
    logic       clear_tick;
    logic       stim_led;
    logic [3:0] bcd3;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
    logic       busy;
    logic       early;
    logic       timeout;

    reaction_ctrl #(
        .MS_DIV      (MSDIV),
        .DELAY_MIN_MS(DMIN),
        .TIMEOUT_MS  (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_tick(start_tick),
        .stop_tick (stop_tick),
        .clear_tick(clear_tick),
        .stim_led  (stim_led),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .busy      (busy),
        .early     (early),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [19:0] v;
    } ev_t;

    ev_t         sbq[$];
    int          cyc = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic [19:0] dv;

    assign dv = {stim_led, busy, early, timeout, bcd3, bcd2, bcd1, bcd0};

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_lfsr <= !reset ? 16'hACE1 : lfsr_step(m_lfsr);
    end

    function automatic logic [19:0] vec(input bit s, input bit b,
                                        input bit e, input bit t,
                                        input int n);
        return {s, b, e, t,
                4'(n / 1000 % 10), 4'(n / 100 % 10),
                4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic push(input int c, input logic [19:0] v);
        sbq.push_back('{c, v});
    endtask

    task automatic push_ticks(input int t0, input int n);
        for (int k = 1; k <= n; k++)
            push(t0 + k * MSDIV, vec(1, 1, 0, 0, k));
    endtask

    // Drive a one-cycle pulse sampled by edge number e.
    task automatic pulse(input int which, input int e);
        while (cyc < e - 1) @(negedge clk);
        start_tick = (which == P_START);
        stop_tick  = (which == P_STOP) || (which == P_SC);
        clear_tick = (which == P_CLEAR) || (which == P_SC);
        @(negedge clk);
        start_tick = 1'b0;
        stop_tick  = 1'b0;
        clear_tick = 1'b0;
    endtask

    task automatic issue_start(input int dforce, input bit with_time,
                               output int t0, output int d);
        int e;
        e  = cyc + 1;
        d  = (dforce >= 0) ? dforce : DMIN + int'(m_lfsr[10:0]);
        t0 = e + d * MSDIV;
        push(e, vec(0, 1, 0, 0, 0));
        if (with_time) push(t0, vec(1, 1, 0, 0, 0));
        start_tick = 1'b1;
        @(negedge clk);
        start_tick = 1'b0;
    endtask

    // Keep run time short by starting when the random delay is small.
    task automatic wait_small();
        for (int i = 0; i < 3000; i++) begin
            if (m_lfsr[10:0] < 11'd200) break;
            @(negedge clk);
        end
    endtask

    initial begin : monitor
        ev_t         ev;
        logic [19:0] prev;
        logic [19:0] cur;
        prev = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = dv;
                if (cur !== prev) begin
                    n_tests++;
                    if (sbq.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected cyc=%0d got=%h required=none",
                                 cyc, cur);
                    end else begin
                        ev = sbq.pop_front();
                        if (ev.cyc != cyc || ev.v !== cur) begin
                            n_fail++;
                            $display("FAIL sb_event got cyc=%0d vec=%h required cyc=%0d vec=%h",
                                     cyc, cur, ev.cyc, ev.v);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : stim
        int t0;
        int d;
        int d1;
        int s;
        reset      = 1'b0;
        start_tick = 1'b0;
        stop_tick  = 1'b0;
        clear_tick = 1'b0;
        repeat (3) @(negedge clk);

        n_tests++;
        if (dv !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state got=%h required=00000", dv);
        end
        mon_en = 1'b1;
        reset  = 1'b1;
        @(negedge clk);

        // Measured reaction of 37 ms
        issue_start(-1, 1'b1, t0, d1);
        push_ticks(t0, 37);
        s = t0 + 37 * MSDIV + int'($urandom_range(1, MSDIV - 1));
        push(s, vec(0, 0, 0, 0, 37));
        pulse(P_STOP, s);

        // Early stop during the delay
        issue_start(-1, 1'b0, t0, d);
        s = cyc + int'($urandom_range(2, 40));
        push(s, vec(0, 0, 1, 0, 9999));
        pulse(P_STOP, s);

        // Restart from EARLY and let it time out
        wait_small();
        issue_start(-1, 1'b1, t0, d);
        push_ticks(t0, TMO - 1);
        push(t0 + TMO * MSDIV, vec(0, 0, 0, 1, TMO));
        while (cyc < t0 + TMO * MSDIV + 3) @(negedge clk);

        // Stop on the same edge as the tick that would give 42
        wait_small();
        issue_start(-1, 1'b1, t0, d);
        push_ticks(t0, 41);
        s = t0 + 42 * MSDIV;
        push(s, vec(0, 0, 0, 0, 41));
        pulse(P_STOP, s);

        // Ignored starts while busy, clear beats stop, stop in IDLE
        wait_small();
        issue_start(-1, 1'b1, t0, d);
        pulse(P_START, cyc + 3);
        push_ticks(t0, 12);
        pulse(P_START, t0 + 5);
        s = t0 + 12 * MSDIV + 4;
        push(s, vec(0, 0, 0, 0, 0));
        pulse(P_SC, s);
        pulse(P_STOP, s + 5);

        // Reset mid-TIME, then the first delay must repeat the first run
        wait_small();
        issue_start(-1, 1'b1, t0, d);
        push_ticks(t0, 7);
        s = t0 + 7 * MSDIV + 6;
        push(s, vec(0, 0, 0, 0, 0));
        while (cyc < s - 1) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue_start(d1, 1'b1, t0, d);
        push(t0 + 5, vec(0, 0, 0, 0, 0));
        pulse(P_CLEAR, t0 + 5);

        repeat (20) @(negedge clk);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain left=%0d required=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
